// File: rtl/reg_read_stage_pkg.sv
// rtl/reg_read_stage_pkg.sv - opcode enum, instruction field union and operand-use decode
// Shared by regfile_bank and reg_read_stage.
package reg_read_stage_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } insn_fields_t;

    typedef union packed {
        logic [31:0]  raw;
        insn_fields_t f;
    } insn_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } operand_use_t;

    function automatic operand_use_t decode_operand_use(input logic [6:0] opcode);
        operand_use_t u;
        u = '0;
        case (opcode)
            OPC_OP, OPC_BRANCH, OPC_STORE: begin
                u.rs1 = 1'b1;
                u.rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: u.rs1 = 1'b1;
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/reg_read_stage_regfile_bank.sv
// rtl/reg_read_stage_regfile_bank.sv - register file with NWB prioritised write ports, two read ports, debug tap
// REGFILE_BYPASS_EN enables same-cycle writeback forwarding on the read ports.
module regfile_bank
    import reg_read_stage_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NREGS     = 32,
    parameter int  NWB       = 2,
    parameter int  DEBUG_REG = 10,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWB-1:0]      wb_en,
    input  logic [NWB*RW-1:0]   wb_reg,
    input  logic [NWB*XLEN-1:0] wb_data,
    input  logic [RW-1:0]       rd_idx_a,
    input  logic [RW-1:0]       rd_idx_b,
    output logic [XLEN-1:0]     rd_data_a,
    output logic [XLEN-1:0]     rd_data_b,
    output logic [XLEN-1:0]     debug
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Ascending port loop: the last non-blocking write wins, giving the highest port priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWB; k++) begin
                if (wb_en[k] && (wb_reg[k*RW +: RW] != '0)) begin
                    regs_q[wb_reg[k*RW +: RW]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [RW-1:0] idx);
        logic [XLEN-1:0] v;
        v = (idx == '0) ? '0 : regs_q[idx];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWB; k++) begin
            if (wb_en[k] && (idx != '0) && (wb_reg[k*RW +: RW] == idx)) begin
                v = wb_data[k*XLEN +: XLEN];
            end
        end
`endif
        return v;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_idx_a);
        rd_data_b = read_port(rd_idx_b);
    end

    assign debug = regs_q[DEBUG_REG];

endmodule

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - register-read stage: operand decode/read and one-entry valid/ready output register
// REGFILE_BYPASS_EN (optional) forwards same-cycle writebacks into operand captures.
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  NREGS     = 32,
    parameter int  NWB       = 2,
    parameter int  DEBUG_REG = 10,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_insn,
    input  logic [NWB-1:0]      wb_en,
    input  logic [NWB*RW-1:0]   wb_reg,
    input  logic [NWB*XLEN-1:0] wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_insn,
    output logic [XLEN-1:0]     out_rs1,
    output logic [XLEN-1:0]     out_rs2,
    output logic [XLEN-1:0]     debug
);

    logic            out_valid_q, out_valid_d;
    insn_t           out_insn_q, out_insn_d;
    logic [XLEN-1:0] out_rs1_q, out_rs1_d;
    logic [XLEN-1:0] out_rs2_q, out_rs2_d;

    logic            load;
    insn_t           rd_insn;
    operand_use_t    use_ops;
    logic [XLEN-1:0] rd_data_a, rd_data_b;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // While holding, the held instruction keeps driving the read ports so late writebacks are picked up.
    always_comb begin
        rd_insn.raw = load ? in_insn : out_insn_q.raw;
        use_ops     = decode_operand_use(rd_insn.f.opcode);
    end

    regfile_bank #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .NWB       (NWB),
        .DEBUG_REG (DEBUG_REG)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .rd_idx_a  (RW'(rd_insn.f.rs1)),
        .rd_idx_b  (RW'(rd_insn.f.rs2)),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .debug     (debug)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_insn_d  = out_insn_q;
        out_rs1_d   = out_rs1_q;
        out_rs2_d   = out_rs2_q;
        if (load) begin
            out_valid_d    = 1'b1;
            out_insn_d.raw = in_insn;
            out_rs1_d      = use_ops.rs1 ? rd_data_a : '0;
            out_rs2_d      = use_ops.rs2 ? rd_data_b : '0;
        end else if (out_valid_q && !out_ready) begin
            out_rs1_d      = use_ops.rs1 ? rd_data_a : '0;
            out_rs2_d      = use_ops.rs2 ? rd_data_b : '0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_insn_q  <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_rs1_q   <= out_rs1_d;
            out_rs2_q   <= out_rs2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_insn  = out_insn_q.raw;
    assign out_rs1   = out_rs1_q;
    assign out_rs2   = out_rs2_q;

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Parametrised register-read pipeline stage: holds the architectural integer register file, decodes which source operands an instruction uses, reads them with same-cycle writeback forwarding, and presents them in a one-entry output register under a valid/ready handshake. It sits between decode and execute. It generalises the single-writeback, stall-pin register stage to N writeback ports, configurable register count and width, and explicit flow control.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers; power of two, >= 2; register 0 hard-wired to zero
- NWB, 2, number of writeback ports; higher index has priority
- DEBUG_REG, 10, register index mirrored on debug output
- Derived RW = $clog2(NREGS)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_insn  in  32  RV32 instruction word
- wb_en  in  NWB  per-port write enable
- wb_reg  in  NWB*RW  per-port destination index, port k at [k*RW +: RW]
- wb_data  in  NWB*XLEN  per-port write data, port k at [k*XLEN +: XLEN]
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream accepts this cycle
- out_insn  out  32  captured instruction
- out_rs1  out  XLEN  operand 1 value, 0 when unused
- out_rs2  out  XLEN  operand 2 value, 0 when unused
- debug  out  XLEN  registers[DEBUG_REG], registered-file value (no forwarding)

## Operation
- Operand use by opcode: RegReg, Branch, Store: rs1 and rs2; RegImm, Jalr, Load: rs1 only, rs2 = 0; all others: both 0.
- Writes: on clk, each port k with wb_en[k] and wb_reg[k] != 0 writes wb_data[k]; writes to register 0 ignored; same-register collision: highest k wins.
- Read value for index r: 0 if r == 0; else, with bypass, wb_data of highest enabled port with matching nonzero wb_reg; else stored value.
- in_ready = !out_valid || out_ready (pure combinational, no bubble on back-to-back flow).
- Load: in_valid && in_ready -> out_insn <= in_insn, operands captured, out_valid <= 1.
- Drain: out_valid && out_ready && !in_valid -> out_valid <= 0; operand/insn values keep last contents.
- Hold: out_valid && !out_ready -> out_insn stable; out_rs1/out_rs2 re-captured every cycle from out_insn's source indices so writebacks landing during a hold are reflected. Consumer samples operands only on the handshake cycle.
- Reset: all registers, out_valid, out_insn, out_rs1, out_rs2 <= 0; held instruction discarded; writebacks during reset cycle ignored.

## Timing
- Latency in_valid handshake -> out_valid: 1 cycle.
- Writeback at edge t visible in stored file after t; with bypass, a read in the same cycle as the write returns new data.
- Throughput 1 instruction/cycle when out_ready held high.
- debug updates the cycle after the write edge.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle writeback forwarding as above on both load and hold captures.
- Undefined: reads return stored value only; a write in cycle t is seen by captures from cycle t+1; decode must insert one bubble on RAW distance 1.

## Structure
- Common package: Opcode enum, instruction field union (Insn), operand-use decode function.
- Sub-module regfile_bank (NREGS x XLEN storage, NWB write ports with priority, two read ports with optional forwarding, debug tap); stage module owns handshake and output register.

## Test plan
- Reset, then read all 32 regs via RegReg insns -> every out_rs1/out_rs2 = 0, debug = 0.
- Port0 write x5=0x11 and port1 write x5=0x22 same cycle, plus add rs1=x5 in -> out_rs1 = 0x22 (bypass) / stored 0x22 next cycle.
- Write x0=0xFFFF_FFFF, then read x0 -> 0.
- Addi rs1=x3 rs2-field=x4 with x4=7 -> out_rs2 = 0; lui -> both operands 0.
- out_ready low 3 cycles with insn using x6, write x6=0x55 during hold -> in_ready=0, out_insn stable, out_rs1 = 0x55 at handshake.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_rs1=0, x1..x31 = 0.
